// File: rtl/calc_pkg.sv
// Shared key codes, output encodings and state type for the BCD calculator sequencer.
package calc_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_EQU = 4'hD;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    localparam logic [2:0] DISP_ZERO = 3'b000;
    localparam logic [2:0] DISP_A    = 3'b001;
    localparam logic [2:0] DISP_OP   = 3'b010;
    localparam logic [2:0] DISP_B    = 3'b011;
    localparam logic [2:0] DISP_RES  = 3'b100;
    localparam logic [2:0] DISP_ERR  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTER_A,
        ST_ENTER_B,
        ST_WAIT_ALU,
        ST_SHOW_RES,
        ST_ERROR
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] code);
        return (code == KEY_ADD) || (code == KEY_SUB);
    endfunction

    function automatic logic [1:0] op_of(input logic [3:0] code);
        return (code == KEY_SUB) ? OP_SUB : OP_ADD;
    endfunction

endpackage

// File: rtl/calc_entry_reg.sv
// BCD operand entry register: shifts digits in from the right, saturating at MAX_DIGITS.
module calc_entry_reg
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_value,
    input  logic [CNT_W-1:0]  load_count,
    input  logic              shift,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] value,
    output logic              has_digits
);

    localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(MAX_DIGITS);

    logic [CNT_W-1:0] count;

    // Clear beats load beats shift; digits beyond MAX_DIGITS are dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            value <= '0;
            count <= '0;
        end else if (clear) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= load_value;
            count <= load_count;
        end else if (shift && (count < COUNT_MAX)) begin
            value <= {value[DATA_W-5:0], digit};
            count <= count + CNT_W'(1);
        end
    end

    assign has_digits = (count != '0);

endmodule

// File: rtl/calc_sequencer.sv
// Key-driven controller for the BCD calculator: operand entry, ALU launch/timeout, display select.
// Optional build macro CALC_CHAIN_EN: an operator after a result chains that result into operand A.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS  = 4,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              key_valid,
    input  logic [3:0]        key_code,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_neg,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [1:0]        op_sel,
    output logic              alu_start,
    output logic              alu_abort,
    output logic [DATA_W-1:0] result,
    output logic              result_neg,
    output logic [2:0]        disp_sel,
    output logic              err
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMO_W = $clog2(ALU_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(ALU_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(MAX_DIGITS);

    state_t state, state_nxt;
    logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
    logic [1:0]        op_sel_nxt;
    logic [2:0]        disp_nxt;
    logic              err_nxt, start_nxt, abort_nxt, capture, clear_all;
    logic              a_load, a_shift, a_has_digits, b_clear, b_shift, b_has_digits;
    logic [DATA_W-1:0] a_load_value;
    logic [CNT_W-1:0]  a_load_count;
    logic              key_clr, key_digit, key_op, key_equ;

    // A non-clear key arriving together with alu_done is dropped.
    assign key_clr   = key_valid && (key_code == KEY_CLR);
    assign key_digit = key_valid && !alu_done && is_digit(key_code);
    assign key_op    = key_valid && !alu_done && is_op(key_code);
    assign key_equ   = key_valid && !alu_done && (key_code == KEY_EQU);

    calc_entry_reg #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_entry_a (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear_all),
        .load       (a_load),
        .load_value (a_load_value),
        .load_count (a_load_count),
        .shift      (a_shift),
        .digit      (key_code),
        .value      (operand_a),
        .has_digits (a_has_digits)
    );

    calc_entry_reg #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_entry_b (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (b_clear),
        .load       (1'b0),
        .load_value ('0),
        .load_count ('0),
        .shift      (b_shift),
        .digit      (key_code),
        .value      (operand_b),
        .has_digits (b_has_digits)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        tmo_nxt      = tmo_cnt;
        op_sel_nxt   = op_sel;
        disp_nxt     = disp_sel;
        err_nxt      = err;
        start_nxt    = 1'b0;
        abort_nxt    = 1'b0;
        capture      = 1'b0;
        clear_all    = 1'b0;
        a_load       = 1'b0;
        a_shift      = 1'b0;
        a_load_value = '0;
        a_load_count = '0;
        b_shift      = 1'b0;
        b_clear      = 1'b0;

        if (key_clr) begin
            state_nxt  = ST_IDLE;
            tmo_nxt    = '0;
            op_sel_nxt = OP_ADD;
            disp_nxt   = DISP_ZERO;
            err_nxt    = 1'b0;
            abort_nxt  = (state == ST_WAIT_ALU);
            clear_all  = 1'b1;
            b_clear    = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_ENTER_A: begin
                    if (key_digit) begin
                        a_shift   = 1'b1;
                        state_nxt = ST_ENTER_A;
                        disp_nxt  = DISP_A;
                    end else if (key_op && a_has_digits) begin
                        op_sel_nxt = op_of(key_code);
                        state_nxt  = ST_ENTER_B;
                        disp_nxt   = DISP_OP;
                    end
                end
                ST_ENTER_B: begin
                    if (key_digit) begin
                        b_shift  = 1'b1;
                        disp_nxt = DISP_B;
                    end else if (key_op && !b_has_digits) begin
                        op_sel_nxt = op_of(key_code);
                    end else if (key_equ && b_has_digits) begin
                        start_nxt = 1'b1;
                        tmo_nxt   = '0;
                        state_nxt = ST_WAIT_ALU;
                    end
                end
                ST_WAIT_ALU: begin
                    if (alu_done) begin
                        capture   = 1'b1;
                        state_nxt = ST_SHOW_RES;
                        disp_nxt  = DISP_RES;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_ERROR;
                        disp_nxt  = DISP_ERR;
                    end else begin
                        tmo_nxt = tmo_cnt + TMO_W'(1);
                    end
                end
                ST_SHOW_RES: begin
                    if (key_digit) begin
                        a_load       = 1'b1;
                        a_load_value = {{(DATA_W-4){1'b0}}, key_code};
                        a_load_count = CNT_W'(1);
                        b_clear      = 1'b1;
                        op_sel_nxt   = OP_ADD;
                        state_nxt    = ST_ENTER_A;
                        disp_nxt     = DISP_A;
                    end else if (key_op) begin
`ifdef CALC_CHAIN_EN
                        a_load       = 1'b1;
                        a_load_value = result;
                        a_load_count = COUNT_FULL;
                        b_clear      = 1'b1;
                        op_sel_nxt   = op_of(key_code);
                        state_nxt    = ST_ENTER_B;
                        disp_nxt     = DISP_OP;
`else
                        state_nxt    = ST_SHOW_RES;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt    <= '0;
            op_sel     <= OP_ADD;
            disp_sel   <= DISP_ZERO;
            err        <= 1'b0;
            alu_start  <= 1'b0;
            alu_abort  <= 1'b0;
            result     <= '0;
            result_neg <= 1'b0;
        end else begin
            tmo_cnt   <= tmo_nxt;
            op_sel    <= op_sel_nxt;
            disp_sel  <= disp_nxt;
            err       <= err_nxt;
            alu_start <= start_nxt;
            alu_abort <= abort_nxt;
            if (clear_all) begin
                result     <= '0;
                result_neg <= 1'b0;
            end else if (capture) begin
                result     <= alu_result;
                result_neg <= alu_neg;
            end
        end
    end

`ifndef CALC_CHAIN_EN
    logic unused_full;
    assign unused_full = ^COUNT_FULL;
`endif

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Central controller for the 4-digit BCD calculator datapath. Consumes decoded key events from the keypad/translation chain and accumulates digits into operand A and operand B. Latches the operator, launches the ALU, waits for completion with a timeout, and selects what the display shows. It sits between key decode and the ALU/display.

Parameters:
MAX_DIGITS, 4, max BCD digits per operand; extra digits are ignored.
ALU_TIMEOUT, 16, cycles to wait for alu_done before flagging an error.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle pulse; key_code is valid this cycle
key_code  in  4  0-9 digit, A add, B subtract, C clear, D equals; E/F ignored
alu_done  in  1  one-cycle pulse; alu_result is valid
alu_result  in  16  BCD result
alu_neg  in  1  result is negative (subtraction)
operand_a  out  16  BCD operand A
operand_b  out  16  BCD operand B
op_sel  out  2  00 add, 01 subtract
alu_start  out  1  one-cycle launch pulse
alu_abort  out  1  one-cycle pulse on clear during WAIT_ALU
result  out  16  captured BCD result
result_neg  out  1  captured sign
disp_sel  out  3  000 zero, 001 A, 010 op, 011 B, 100 result, 101 error
err  out  1  timeout error flag

Behaviour:
- Reset (resetn low, async): state IDLE; all outputs, both digit counters and the timeout counter are 0.
- All key effects register on the clk edge that samples key_valid. Outputs change one cycle after the key.
- States: IDLE, ENTER_A, ENTER_B, WAIT_ALU, SHOW_RES, ERROR.
- Digit key, IDLE/ENTER_A:
  - If count_a < MAX_DIGITS: operand_a <= {operand_a[11:0], digit}, count_a++. Otherwise no change (saturate).
  - Next state ENTER_A; disp_sel 001.
- Operator key:
  - ENTER_A: latch op_sel, go to ENTER_B, disp_sel 010.
  - ENTER_B with count_b=0: replace op_sel.
  - ENTER_B with count_b>0: ignored.
  - IDLE: ignored.
- Digit key, ENTER_B: shift into operand_b with the same saturation rule; disp_sel 011.
- Equals key:
  - ENTER_B with count_b>0: alu_start high for exactly 1 cycle (the cycle after the key); go to WAIT_ALU; timeout counter cleared.
  - Equals anywhere else: ignored.
- WAIT_ALU:
  - All keys except clear are ignored.
  - On alu_done: result <= alu_result, result_neg <= alu_neg; go to SHOW_RES; disp_sel 100.
  - Timeout counter increments every cycle. Reaching ALU_TIMEOUT without alu_done: go to ERROR, err=1, disp_sel 101. A late alu_done in ERROR is ignored.
- SHOW_RES:
  - Digit key: clear operands, counters and op_sel; load the digit as the first digit of A; go to ENTER_A.
  - Operator key: see Optional Feature.
- ERROR: only clear exits.
- Clear key, any state: next cycle everything returns to reset values and state is IDLE. If in WAIT_ALU, alu_abort pulses 1 cycle.
- Simultaneous events:
  - Clear and alu_done in the same cycle: clear wins and result is not captured.
  - key_valid and alu_done in the same cycle (non-clear key): the key is dropped.
- key_code E/F: ignored in every state.

Optional Feature:
CALC_CHAIN_EN
- Defined: an operator key in SHOW_RES copies result into operand_a, sets count_a=MAX_DIGITS, clears operand_b/count_b, latches op_sel, goes to ENTER_B, disp_sel 010. result_neg is kept.
- Undefined: an operator key in SHOW_RES is ignored.

Decomposition:
- Package calc_pkg:
  - key code constants (KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_CLR=4'hC, KEY_EQU=4'hD)
  - op_sel encodings
  - disp_sel encodings
  - state enum typedef
- Sub-module calc_entry_reg: BCD shift register plus saturating digit counter, with load/clear/shift controls. Instantiated twice, for A and B.

Test Plan:
- Hold resetn low mid-entry (operand_a=0x0012) -> all outputs 0 immediately; state IDLE; disp_sel 000.
- Keys 1,2,3,A,4,5,D; alu_done with 0x0168 three cycles after alu_start -> operand_a 0x0123, op_sel 00, operand_b 0x0045, single alu_start pulse one cycle after D, result 0x0168, disp_sel 100.
- Keys 1,2,3,4,5 -> operand_a 0x1234, fifth digit ignored; key E -> no change.
- Keys 9,B,3,D, alu_done withheld -> err=1 and disp_sel 101 exactly 16 cycles after alu_start; then C -> IDLE, err=0.
- Keys 2,A,2,D; C coincident with alu_done -> IDLE, result stays 0; alu_abort pulses once.
- From result 0x0168, press B -> with CALC_CHAIN_EN: operand_a 0x0168, op_sel 01, ENTER_B. Without it: state SHOW_RES unchanged.
